// File: rtl/sparc_ifu_sscan_hist.sv
// sparc_ifu_sscan_hist: snapshot history buffer with periodic capture and JTAG readout
`ifndef CORE_JTAG_BUS_WIDTH
`define CORE_JTAG_BUS_WIDTH 64
`endif
`ifndef JTAG_CORE_ID_WIDTH
`define JTAG_CORE_ID_WIDTH 3
`endif
`ifndef JTAG_CORE_ID_IFU_SSCAN
`define JTAG_CORE_ID_IFU_SSCAN 5
`endif
module sparc_ifu_sscan_hist #(
  parameter int DATA_W  = 94,
  parameter int BUS_W   = `CORE_JTAG_BUS_WIDTH,
  parameter int DEPTH   = 4,
  parameter int CORE_ID = `JTAG_CORE_ID_IFU_SSCAN
) (
  input  logic                           rclk,
  input  logic                           arst_l,
  input  logic [DATA_W-1:0]              sscan_data,
  input  logic                           rtap_core_val,
  input  logic [`JTAG_CORE_ID_WIDTH-1:0] rtap_core_id,
  input  logic [BUS_W-1:0]               rtap_core_data,
  output logic                           core_rtap_val,
  output logic [BUS_W-1:0]               core_rtap_data
);
  localparam int IW = `JTAG_CORE_ID_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NB = (DATA_W + BUS_W - 1) / BUS_W;
  localparam int SW = NB * BUS_W;
  localparam int BW = $clog2(NB + 1);
  typedef enum logic [1:0] {IDLE, HDR, DATA} st_t;
  st_t st_q, st_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, armed_q, armed_d;
  logic [15:0] ival_q, ival_d, icnt_q, icnt_d;
  logic [9:0] hdr_q, hdr_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [BW-1:0] bt_q, bt_d;
  logic acc, fire, push, rd, clr, arm, pop, full;
  logic [3:0] opc;
  logic [15:0] ivl_in;
  assign acc    = rtap_core_val && rtap_core_id == IW'(CORE_ID);
  assign opc    = rtap_core_data[3:0];
  assign ivl_in = rtap_core_data[31:16];
  assign fire   = armed_q && icnt_q == ival_q - 16'd1;
  assign push   = fire || (acc && opc == 4'd0);
  assign rd     = acc && opc == 4'd1 && st_q == IDLE;
  assign clr    = acc && opc == 4'd2 && st_q == IDLE;
  assign arm    = acc && opc == 4'd3;
  assign pop    = rd && cnt_q != '0;
  assign full   = cnt_q == CW'(DEPTH);
  assign core_rtap_val  = st_q != IDLE;
  assign core_rtap_data = st_q == HDR ? BUS_W'(hdr_q) : st_q == DATA ? sh_q[BUS_W-1:0] : '0;
  // Next state for buffer bookkeeping, periodic capture timer and readout FSM
  always_comb begin
    st_d    = st_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    armed_d = armed_q;
    ival_d  = ival_q;
    icnt_d  = icnt_q;
    hdr_d   = hdr_q;
    sh_d    = sh_q;
    bt_d    = bt_q;
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (push) begin
      wp_d = wp_q + PW'(1);
      if (pop || full) rp_d = rp_q + PW'(1);
      if (!pop && full) ovf_d = 1'b1;
      if (!pop && !full) cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      rp_d  = rp_q + PW'(1);
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) ovf_d = 1'b0;
    end
    if (arm) begin
      armed_d = ivl_in != 16'd0;
      ival_d  = ivl_in;
      icnt_d  = '0;
    end else if (armed_q) begin
      icnt_d = fire ? 16'd0 : icnt_q + 16'd1;
    end
    case (st_q)
      IDLE: if (rd) begin
        st_d  = HDR;
        hdr_d = {cnt_q == '0, ovf_q, 8'(cnt_q)};
        sh_d  = SW'(mem_q[rp_q]);
      end
      HDR: begin
        st_d = hdr_q[9] ? IDLE : DATA;
        bt_d = '0;
      end
      DATA: begin
        sh_d = sh_q >> BUS_W;
        bt_d = bt_q + BW'(1);
        st_d = bt_q == BW'(NB - 1) ? IDLE : DATA;
      end
      default: st_d = IDLE;
    endcase
  end
  // Control state with asynchronous reset
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      st_q    <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      armed_q <= 1'b0;
      ival_q  <= '0;
      icnt_q  <= '0;
      hdr_q   <= '0;
      sh_q    <= '0;
      bt_q    <= '0;
    end else begin
      st_q    <= st_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      armed_q <= armed_d;
      ival_q  <= ival_d;
      icnt_q  <= icnt_d;
      hdr_q   <= hdr_d;
      sh_q    <= sh_d;
      bt_q    <= bt_d;
    end
  end
  // Snapshot storage, no reset needed since count gates every read
  always_ff @(posedge rclk) begin
    if (push && !clr) mem_q[wp_q] <= sscan_data;
  end
endmodule
